instr_fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_next_pc.sv | 28 ++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection, redirect alignment check and end-of-program compares.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] LAST_ADDR = 32'd52
) (
  input  logic [31:0] i_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_target_aligned,
  output logic        o_target_past_end,
  output logic        o_seq_past_end
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4        = i_pc + 32'(INSTR_BYTES);
  assign o_pc_plus4        = w_pc_plus4;
  assign o_target_aligned  = (i_redirect_target[1:0] == 2'b00);
  assign o_target_past_end = (i_redirect_target > LAST_ADDR);
  assign o_seq_past_end    = (w_pc_plus4 > LAST_ADDR);

  // A misaligned target never replaces the PC; the sequential address is offered instead.
  assign o_next_pc = (i_redirect_valid && o_target_aligned) ? i_redirect_target : w_pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, control FSM and valid/ready output stage toward decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] LAST_ADDR = 32'd52,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rd,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_n;
  logic [31:0]       r_pc;
  logic              r_vld_p1;
  logic [31:0]       r_instr_p1;
  logic [31:0]       r_pc_p1;
  logic [31:0]       r_pc_plus4_p1;
  logic [CNT_W-1:0]  r_fetch_count;

  logic [31:0]       w_pc_plus4;
  logic [31:0]       w_next_pc;
  logic              w_target_aligned;
  logic              w_target_past_end;
  logic              w_seq_past_end;
  logic              w_take_redirect;
  logic              w_capture;

  fetch_next_pc #(
    .LAST_ADDR(LAST_ADDR)
  ) u_next_pc (
    .i_pc              (r_pc),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_pc_plus4        (w_pc_plus4),
    .o_next_pc         (w_next_pc),
    .o_target_aligned  (w_target_aligned),
    .o_target_past_end (w_target_past_end),
    .o_seq_past_end    (w_seq_past_end)
  );

  // Redirects outrank everything except a latched fault.
  always_comb begin
    w_state_n       = r_state;
    w_take_redirect = 1'b0;
    w_capture       = 1'b0;
    if (redirect_valid && (r_state != ST_FAULT)) begin
      w_take_redirect = 1'b1;
      if (!w_target_aligned)      w_state_n = ST_FAULT;
      else if (w_target_past_end) w_state_n = ST_HALT;
      else                        w_state_n = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: w_state_n = ST_RUN;
        ST_RUN: begin
          if (!r_vld_p1 || out_ready) begin
            w_capture = 1'b1;
            if (w_seq_past_end) w_state_n = ST_HALT;
          end
        end
        default: w_state_n = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_n;
      if ((w_take_redirect && w_target_aligned) || w_capture) r_pc <= w_next_pc;
      if (w_capture) r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  // ---- stage p1: registered instruction toward decode ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_instr_p1    <= '0;
      r_pc_p1       <= '0;
      r_pc_plus4_p1 <= 32'd4;
    end else if (w_take_redirect) begin
      r_vld_p1 <= 1'b0;
    end else if (w_capture) begin
      r_vld_p1      <= 1'b1;
      r_instr_p1    <= imem_rd;
      r_pc_p1       <= r_pc;
      r_pc_plus4_p1 <= w_pc_plus4;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign imem_addr    = r_pc;
  assign out_valid    = r_vld_p1;
  assign out_instr    = r_instr_p1;
  assign out_pc       = r_pc_p1;
  assign out_pc_plus4 = r_pc_plus4_p1;
  assign halted       = (r_state == ST_HALT);
  assign fault        = (r_state == ST_FAULT);
  assign fetch_count  = r_fetch_count;

endmodule
